// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store ports.
// One access in flight at a time; fixed memory latency counted down in WAIT.
module mem_arbiter #(
  parameter int WIDTH          = 32,
  parameter int MEM_LAT        = 2,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  input  logic             if_flush,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [WIDTH-1:0] dm_addr,
  input  logic [WIDTH-1:0] dm_wdata,
  input  logic [3:0]       dm_be,
  output logic             dm_gnt,
  output logic             dm_rvalid,
  output logic [WIDTH-1:0] dm_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy
);

  // state   | meaning
  // S_IDLE  | arbitrate, grant combinationally, latch winner
  // S_ISSUE | mem_req strobe, load latency counter
  // S_WAIT  | count latency, capture read data at cnt==0
  // S_RESP  | rvalid pulse to the owning port
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
  localparam logic [3:0] BURST  = 4'(MAX_DATA_BURST);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic [3:0] streak;
  logic       owner_if;
  logic       flushed;
  logic       if_rvalid_q;
  logic       grant_if, grant_dm;
  logic       fetch_win;

  assign fetch_win = if_req && (!dm_req || streak == BURST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    case (state)
      S_IDLE: begin
        // gnt is held low while reset is asserted
        if (rst) begin
          if (fetch_win)   grant_if = 1'b1;
          else if (dm_req) grant_dm = 1'b1;
        end
        if (grant_if || grant_dm) state_nxt = S_ISSUE;
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (cnt == 4'd0) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign if_gnt  = grant_if;
  assign dm_gnt  = grant_dm;
  assign mem_req = (state == S_ISSUE);
  assign busy    = (state != S_IDLE);
  // a flush in the RESP cycle itself must still kill the pulse
  assign if_rvalid = if_rvalid_q & ~if_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= 4'd0;
      streak      <= 4'd0;
      owner_if    <= 1'b0;
      flushed     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= 4'h0;
      if_rvalid_q <= 1'b0;
      if_rdata    <= '0;
      dm_rvalid   <= 1'b0;
      dm_rdata    <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      dm_rvalid   <= 1'b0;

      if (grant_if || grant_dm) begin
        owner_if  <= grant_if;
        flushed   <= grant_if & if_flush;
        mem_we    <= grant_dm & dm_we;
        mem_addr  <= grant_if ? if_addr : dm_addr;
        mem_wdata <= grant_if ? '0 : dm_wdata;
        mem_be    <= grant_if ? 4'hF : dm_be;
        if (grant_if)             streak <= 4'd0;
        else if (streak != BURST) streak <= streak + 4'd1;
      end else if (owner_if && if_flush) begin
        flushed <= 1'b1;
      end

      if (state == S_ISSUE) begin
        cnt <= LAT_M1;
      end else if (state == S_WAIT) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else if (owner_if) begin
          if_rdata    <= mem_rdata;
          if_rvalid_q <= ~(flushed | if_flush);
        end else begin
          dm_rdata  <= mem_we ? '0 : mem_rdata;
          dm_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port unified memory between the instruction-fetch port and the load/store data port of the RV32I core. It arbitrates between the two requesters, issues one memory access at a time, counts the fixed memory latency, and returns read data or a write acknowledge to the winning port. It sits between the fetch/memory stages and the memory macro, and supplies the `busy` indication used to stall the PC.

## Interface
- `WIDTH`, 32, data and address width.
- `MEM_LAT`, 2, memory read latency in cycles, counted from the `mem_req` cycle; legal range 1–15.
- `MAX_DATA_BURST`, 4, maximum consecutive data-port grants while fetch is waiting; legal range 1–15.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `if_req` input 1: fetch read request.
- `if_addr` input WIDTH: fetch address.
- `if_flush` input 1: discard any in-flight fetch response.
- `if_gnt` output 1: fetch request accepted this cycle.
- `if_rvalid` output 1: fetch read data valid, one-cycle pulse.
- `if_rdata` output WIDTH: fetch read data.
- `dm_req` input 1: data request.
- `dm_we` input 1: data request is a write.
- `dm_addr` input WIDTH: data address.
- `dm_wdata` input WIDTH: write data.
- `dm_be` input 4: byte enables.
- `dm_gnt` output 1: data request accepted this cycle.
- `dm_rvalid` output 1: load data valid, or write-complete acknowledge; one-cycle pulse.
- `dm_rdata` output WIDTH: load data; 0 on write acknowledge.
- `mem_req` output 1: memory access strobe, one cycle.
- `mem_we` output 1: memory write.
- `mem_addr` output WIDTH: memory address.
- `mem_wdata` output WIDTH: memory write data.
- `mem_be` output 4: memory byte enables; `4'hF` for fetch.
- `mem_rdata` input WIDTH: memory read data, valid `MEM_LAT` cycles after `mem_req`.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- **One outstanding access.** The FSM has four states: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**
  - If any request is present, compute the winner and assert its `*_gnt` combinationally.
  - On the clock edge, latch the winner's address, wdata, be and we into the `mem_*` registers, record the owner (fetch or data), and go to ISSUE.
- **ISSUE**
  - `mem_req`=1 for exactly this cycle.
  - Load `cnt` ← `MEM_LAT`−1 and go to WAIT.
- **WAIT**
  - If `cnt`==0, capture `mem_rdata` (or 0 for a write) into the owner's rdata register and go to RESP.
  - Otherwise decrement `cnt`.
- **RESP**
  - Pulse the owner's `*_rvalid` and go to IDLE.
- **Arbitration**
  - The data port has priority.
  - Exception: fetch wins when `if_req`=1 and `streak`==`MAX_DATA_BURST`.
  - A lone requester always wins.
- **`streak` counter**
  - Width 4 bits.
  - Increments on each data grant and saturates at `MAX_DATA_BURST`.
  - Clears to 0 on each fetch grant.
- **Request rules**
  - A requester holds `req` and its address/data stable until `gnt`.
  - A `req` still high after `gnt` counts as a new request and is arbitrated at the next IDLE.
- **Flush**
  - If `if_flush` is high in any cycle from fetch grant through RESP of a fetch access, that access's `if_rvalid` is suppressed.
  - The memory access still completes, and the FSM timing is unchanged.
  - `if_flush` has no effect on data accesses or on a fetch request not yet granted.
- **Writes** follow the same FSM path. `dm_rvalid` pulses in RESP with `dm_rdata`=0.
- **`mem_*` outputs** hold their last values outside ISSUE; only `mem_req` qualifies them.

## Timing
- **Reset** (`rst` low, asynchronous):
  - State → IDLE; `cnt`, `streak` and the owner/flush flags → 0.
  - All outputs go 0 immediately, including `mem_req`, both rdata registers and `busy`.
  - An access in flight is abandoned with no `rvalid`.
- **Access timeline** for a grant in cycle T:
  - `mem_req` in T+1.
  - `mem_rdata` sampled at the end of cycle T+1+`MEM_LAT`.
  - `*_rvalid` in T+2+`MEM_LAT`.
  - Next possible grant in T+3+`MEM_LAT`.
- **Throughput:** one access per `MEM_LAT`+3 cycles.
- **`gnt`** is combinational from `req`, state and `streak`. It is never high outside IDLE, and the two `gnt` outputs are never high together.
- **`busy`** is high from T+1 through T+2+`MEM_LAT` inclusive.
- **`rvalid`** is registered. `if_rdata`/`dm_rdata` hold their value until the next response to the same port.
- **Simultaneous requests in IDLE:** the data port wins unless the `streak` rule applies.

## Test plan
- **Reset mid-access:** pull `rst` low in the WAIT cycle of a load, then release → `mem_req`, `busy`, `dm_rvalid`, `dm_rdata` all 0 at once; the next request is granted in its first IDLE cycle.
- **Single fetch, `MEM_LAT`=2:** `if_req`, `if_addr`=0x100 in cycle 0 → `if_gnt` in 0; `mem_req`/`mem_addr`=0x100/`mem_be`=F in 1; `mem_rdata`=0x00500093 presented in 3; `if_rvalid`=1, `if_rdata`=0x00500093 in 4; `busy` high in 1–4.
- **Simultaneous requests:** `if_req` and `dm_req` both high from cycle 0 with `streak`=0 → `dm_gnt` in 0; `if_gnt` in 5 (`MEM_LAT`=2).
- **Starvation bound:** `dm_req` held high continuously with `if_req` high and `MAX_DATA_BURST`=4 → four `dm_gnt`, then one `if_gnt`, then data resumes.
- **Write:** `dm_we`=1, `dm_addr`=0x2000, `dm_wdata`=0xDEADBEEF, `dm_be`=0x3 → `mem_we`=1 with those values on `mem_*` in T+1; `dm_rvalid` with `dm_rdata`=0 in T+4.
- **Flush:** fetch granted in T, `if_flush` pulsed in T+2 → no `if_rvalid` in T+4; `busy` still drops after T+4; the next fetch completes normally.
